// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the async FIFO: write-pointer input from the
// synchronizer path, memory read port, Gray read pointer back to the write
// side, status flags and the first-word-fall-through output handshake.
interface fifo_rd_ctrl_if #(
  parameter int datawidth  = 8,
  parameter int addr_width = 3
);
  logic [addr_width:0]   wptr_gray;
  logic [addr_width-1:0] raddr;
  logic [datawidth-1:0]  rdata_mem;
  logic [addr_width:0]   rptr_gray;
  logic                  rempty;
  logic [addr_width:0]   rlevel;
  logic                  raempty;
  logic [datawidth-1:0]  dout;
  logic                  dout_valid;
  logic                  dout_ready;

  // Controller side
  modport master (
    input  wptr_gray, rdata_mem, dout_ready,
    output raddr, rptr_gray, rempty, rlevel, raempty, dout, dout_valid
  );

  // Memory / write domain / consumer side
  modport slave (
    output wptr_gray, rdata_mem, dout_ready,
    input  raddr, rptr_gray, rempty, rlevel, raempty, dout, dout_valid
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO, entirely in the rclk domain.
// Synchronizes the Gray write pointer, keeps the binary/Gray read pointer,
// derives empty/level/almost-empty and fetches memory words into a
// first-word-fall-through output register with a valid/ready handshake.
module fifo_rd_ctrl #(
  parameter int datawidth     = 8,
  parameter int addr_width    = 3,
  parameter int aempty_thresh = 1
) (
  input logic            rclk,
  input logic            rrst_n,
  fifo_rd_ctrl_if.master rd
);

  localparam int AW = addr_width;
  typedef logic [AW:0] ptr_t;
  localparam ptr_t AE_TH = ptr_t'(aempty_thresh);

  ptr_t                 wq1, wq2, wq2_bin;
  ptr_t                 rbin, rbinnext, rgraynext, rptr_q;
  ptr_t                 rlevel_c;
  logic                 rempty_q;
  logic                 dout_valid_q;
  logic                 rinc;
  logic [datawidth-1:0] dout_q;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    wq2_bin = '0;
    for (int i = 0; i <= AW; i++) begin
      wq2_bin[i] = ^(wq2 >> i);
    end
  end

  // Fetch whenever memory has data and the output register is free or being drained
  always_comb begin
    rinc      = ~rempty_q & (~dout_valid_q | rd.dout_ready);
    rbinnext  = rbin + ptr_t'(rinc);
    rgraynext = (rbinnext >> 1) ^ rbinnext;
    rlevel_c  = wq2_bin - rbin;
  end

  // Two-flop synchronizer for the write pointer coming from the write clock domain
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= rd.wptr_gray;
      wq2 <= wq1;
    end
  end

  // Read pointer and empty flag; empty looks ahead at rgraynext so fetches run without bubbles
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin     <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin     <= rbinnext;
      rptr_q   <= rgraynext;
      rempty_q <= (rgraynext == wq2);
    end
  end

  // Output register: load on fetch, drop valid when drained without a refill
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (rinc) begin
      dout_q       <= rd.rdata_mem;
      dout_valid_q <= 1'b1;
    end else if (dout_valid_q && rd.dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

  // The word held in dout is already out of memory, so it is not in rlevel
  assign rd.raddr      = rbin[AW-1:0];
  assign rd.rptr_gray  = rptr_q;
  assign rd.rempty     = rempty_q;
  assign rd.rlevel     = rlevel_c;
  assign rd.raempty    = (rlevel_c <= AE_TH);
  assign rd.dout       = dout_q;
  assign rd.dout_valid = dout_valid_q;

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the async FIFO. It runs entirely in the read clock domain and brings the write domain's Gray write pointer in through a 2-flop synchronizer. It generates the read address into the dual-port FIFO memory and the empty, level and almost-empty flags, and returns the Gray read pointer to the write side. The memory's combinational read data is captured into a first-word-fall-through output register with a valid/ready handshake toward the consumer.

## Interface
- datawidth, 8, width of one FIFO word; must match the memory
- addr_width, 3, memory address width; depth = 1<<addr_width
- aempty_thresh, 1, raempty asserts when rlevel <= this value
- rclk  in  1  read clock; all state updates on the rising edge
- rrst_n  in  1  reset, asynchronous assert, active-low; release is synchronous to rclk, handled upstream
- wptr_gray  in  addr_width+1  write pointer, Gray-coded, from the write domain; changes at most one bit per write
- raddr  out  addr_width  read address to memory raddr
- rdata_mem  in  datawidth  memory read data, combinational on raddr
- rptr_gray  out  addr_width+1  registered Gray read pointer, sent to the write domain
- rempty  out  1  memory holds no unread word (registered)
- rlevel  out  addr_width+1  words in memory not yet fetched; range 0..depth
- raempty  out  1  rlevel <= aempty_thresh
- dout  out  datawidth  output word
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  consumer accepts dout this cycle

## Operation
- **Synchronizer:** wq1 <= wptr_gray, then wq2 <= wq1. Both reset to 0. wq2 is converted Gray→binary to give wq2_bin.
- **Read pointer:** rbin is an (addr_width+1)-bit binary pointer. raddr = rbin[addr_width-1:0].
  - rbinnext = rbin + rinc; rgraynext = (rbinnext>>1) ^ rbinnext.
  - At each edge: rbin <= rbinnext, rptr_gray <= rgraynext, rempty <= (rgraynext == wq2).
- **Fetch:** rinc = ~rempty & (~dout_valid | dout_ready).
  - On rinc: dout <= rdata_mem and dout_valid <= 1.
  - On dout_valid & dout_ready & ~rinc: dout_valid <= 0.
  - Otherwise dout and dout_valid hold.
- **Handshake:** a transfer happens on an edge where dout_valid & dout_ready.
  - While dout_valid & ~dout_ready, dout is stable.
  - Accept and fetch in the same cycle replace dout; dout_valid stays 1.
- **Level:** rlevel = wq2_bin - rbin, modulo 2^(addr_width+1). It is computed from registered values only, so it is glitch-free in the rclk domain.
  - The word held in dout is not counted.
  - raempty = (rlevel <= aempty_thresh).
- **Boundary conditions:**
  - Both pointers wrap naturally at 2^(addr_width+1); the MSB difference distinguishes full from empty.
  - rlevel = depth when the memory is full.
  - The flags are conservative: a new write is seen only after synchronization, and rempty/rlevel never overstate the data available.
- **Reset:** when rrst_n is low, at any time including mid-burst, all registers clear immediately.
  - Reset values: wq1 = wq2 = 0, rbin = 0, raddr = 0, rptr_gray = 0, rempty = 1, dout_valid = 0, dout = 0, rlevel = 0, raempty = 1.
  - The write side must be reset at the same time; any word held in dout is discarded.

## Timing
- A wptr_gray change first sampled at rclk edge k:
  - wq2 updates at edge k+1.
  - rempty falls at edge k+2.
  - dout/dout_valid are loaded at edge k+3.
  - rlevel reflects the write after edge k+1.
- Throughput is 1 word per rclk while the memory is non-empty and dout_ready = 1. rempty uses rgraynext, so there is no bubble between back-to-back fetches.
- A fetch at edge n updates raddr and rptr_gray at edge n, i.e. the same edge as dout.
- rptr_gray is a flop output and changes at most one bit per edge, so it is safe for the write-domain synchronizer.
- There are no combinational paths from wptr_gray or dout_ready to any output, except that raddr feeds memory read data combinationally.

## Test plan
All scenarios use default parameters.
- **Reset:** pulse rrst_n low mid-clock with wptr_gray = 0 → rempty = 1, dout_valid = 0, raddr = 0, rptr_gray = 0, rlevel = 0, raempty = 1, each asserted immediately, without waiting for an rclk edge.
- **Single word:** mem[0] = 8'hA5, wptr_gray 0→4'b0001 before edge k, dout_ready = 0.
  - Expect rlevel = 1 after k+1, rempty = 0 after k+2.
  - Expect dout = 8'hA5 and dout_valid = 1 after k+3, with raddr = 1, rptr_gray = 4'b0001, rlevel = 0.
  - dout stays stable for 10 cycles.
- **Full drain:** mem[i] = 8'h10+i, wptr_gray stepped in Gray to 4'b1100 (binary 8), dout_ready = 0.
  - Expect rlevel = 8, then 7 once dout loads.
  - Then dout_ready = 1 → 8'h10..8'h17 on 8 consecutive edges; final rptr_gray = 4'b1100, rempty = 1, raempty = 1.
- **Backpressure:** dout_ready toggles every cycle while 8 words stream → each word transferred exactly once, in order, with dout unchanged on every stalled cycle.
- **Wrap-around:** 20 words are written in bursts of 4, interleaved with reads.
  - Expect rbin to wrap past 15, data order preserved, and rlevel never above 8.
  - Expect raempty to assert exactly when rlevel <= 1.
- **Reset mid-burst:** rrst_n is asserted with dout_valid = 1 and rlevel = 5 → all outputs return to their reset values in the same cycle. After release with wptr_gray = 0, the block stays empty.
